// File: rtl/uart_pkg.sv
// Shared UART definitions: baud constants, frame widths and FSM encoding.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int BAUD_END_SYN = 5207;
  localparam int BAUD_END_SIM = 28;
  localparam int BAUD_CNT_W   = 13;

  localparam int BIT_END   = 8;
  localparam int BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..BAUD_END while enabled and flags the wrap.
// Held at zero while disabled so every bit period starts aligned.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BAUD_END = BAUD_END_SYN
) (
  input  logic sclk,
  input  logic s_rst,
  input  logic enable,
  output logic bit_end
);

  localparam logic [BAUD_CNT_W-1:0] CNT_END = BAUD_CNT_W'(BAUD_END);

  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BAUD_CNT_W-1:0] cnt_d;
  logic                  wrap;

  always_comb begin
    wrap  = (cnt_q == CNT_END);
    cnt_d = cnt_q + 1'b1;
    if (!enable || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = enable && wrap;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with registered outputs.
// Optional even parity bit before the stop bit when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_END = BAUD_END_SYN
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       rs232_tx
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BIT_END - 1);

  uart_state_e          state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           data_q, data_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_en;
  logic                 bit_end;

  assign baud_en = (state_q != ST_IDLE);

  uart_baud_cnt #(
    .BAUD_END(BAUD_END)
  ) u_baud_cnt (
    .sclk   (sclk),
    .s_rst  (s_rst),
    .enable (baud_en),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pi_flag) begin
          state_d   = ST_START;
          data_d    = pi_data;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
      ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_end) begin
          state_d = ST_STOP;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the next state so they appear one cycle after the decision.
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_cnt_d[2:0]];
      ST_PARITY: tx_d = even_parity(data_d);
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rs232_tx = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-position reference model, mid-bit
// sampling receiver, directed scenarios and a randomized traffic phase.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int N = BAUD_END_SIM + 1;
`ifdef UART_TX_PARITY_EN
  localparam int FLEN     = 11;
  localparam int BUSY_LIT = 319;
`else
  localparam int FLEN     = 10;
  localparam int BUSY_LIT = 290;
`endif

  logic       sclk = 1'b0;
  logic       s_rst = 1'b1;
  logic [7:0] pi_data = 8'h00;
  logic       pi_flag = 1'b0;
  logic       tx_busy, tx_done, rs232_tx;

  always #5 sclk = ~sclk;

  uart_tx #(.BAUD_END(BAUD_END_SIM)) dut (
    .sclk    (sclk),
    .s_rst   (s_rst),
    .pi_data (pi_data),
    .pi_flag (pi_flag),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .rs232_tx(rs232_tx)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: position inside the frame selects the expected line bit.
  logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic       m_bits [11];
  logic [7:0] acc_q [$];

  always @(posedge sclk) begin
    cyc++;
    if (s_rst) begin
      if (m_active && acc_q.size() > 0) void'(acc_q.pop_back());
      m_active = 1'b0;
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      if (!exp_busy && pi_flag) begin
        for (int i = 0; i < 11; i++) m_bits[i] = 1'b1;
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[i+1] = pi_data[i];
`ifdef UART_TX_PARITY_EN
        m_bits[9] = ^pi_data;
`endif
        m_bits[FLEN-1] = 1'b1;
        m_active = 1'b1;
        m_pos = 0;
        acc_q.push_back(pi_data);
      end
      if (m_active) begin
        m_pos++;
        if (m_pos <= FLEN * N) begin
          exp_busy = 1'b1; exp_done = 1'b0; exp_tx = m_bits[(m_pos-1)/N];
        end else begin
          exp_busy = 1'b0; exp_done = 1'b1; exp_tx = 1'b1;
          m_active = 1'b0;
        end
      end else begin
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      end
    end
  end

  always @(posedge sclk) begin
    #1;
    if (cmp_en) begin
      chk("rs232_tx", rs232_tx, exp_tx);
      chk("tx_busy", tx_busy, exp_busy);
      chk("tx_done", tx_done, exp_done);
    end
  end

  // Loopback receiver sampling mid-bit, plus busy/done bookkeeping.
  logic       prev_line = 1'b1;
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_idx;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_par = 1'b0;
  logic [7:0] rx_q [$];
  int         busy_run = 0, last_busy_len = 0, done_cnt = 0, busy_total = 0;

  always @(posedge sclk) begin
    #1;
    if (!cmp_en || s_rst) begin
      rx_active = 1'b0;
      prev_line = 1'b1;
    end else begin
      if (rx_active) begin
        rx_cnt++;
        if (rx_cnt % N == N / 2) begin
          rx_idx = rx_cnt / N;
          if (rx_idx >= 1 && rx_idx <= 8) rx_byte[rx_idx-1] = rs232_tx;
          else if (rx_idx == FLEN - 1) begin
            if (rs232_tx === 1'b1) rx_q.push_back(rx_byte);
            rx_active = 1'b0;
          end else if (rx_idx == 9) rx_par = rs232_tx;
        end
      end else if (prev_line === 1'b1 && rs232_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
      prev_line = rs232_tx;
    end
    if (cmp_en) begin
      if (tx_busy === 1'b1) begin
        busy_run++;
        busy_total++;
      end else if (busy_run > 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
      if (tx_done === 1'b1) done_cnt++;
    end
  end

  task automatic pulse(input logic [7:0] d);
    @(posedge sclk); #2;
    pi_flag = 1'b1; pi_data = d;
    @(posedge sclk); #2;
    pi_flag = 1'b0; pi_data = 8'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 12 * N + 20; i++) begin
      @(posedge sclk); #1;
      if (tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    #1;
  endtask

  task automatic chk_rx(input string nm, input int idx, input logic [7:0] exp);
    if (rx_q.size() > idx) chk(nm, rx_q[idx], exp);
    else chk({nm, "_missing"}, rx_q.size(), idx + 1);
  endtask

  int d0;

  initial begin
    s_rst = 1'b1;
    repeat (3) @(posedge sclk);
    cmp_en = 1'b1;
    #2 s_rst = 1'b0;
    chk("rst_tx", rs232_tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);

    repeat (100) @(posedge sclk);
    #2;
    chk("idle_busy_cycles", busy_total, 0);
    chk("idle_done_count", done_cnt, 0);

    // A5: single frame
    rx_q.delete(); d0 = done_cnt;
    pulse(8'hA5);
    wait_done();
    chk_rx("a5_byte", 0, 8'hA5);
    chk("a5_busy_len", last_busy_len, BUSY_LIT);
    repeat (40) @(posedge sclk); #2;
    chk("a5_done_pulses", done_cnt - d0, 1);

    // 3C with an ignored request mid-frame
    rx_q.delete(); d0 = done_cnt;
    pulse(8'h3C);
    repeat (98) @(posedge sclk);
    pulse(8'hFF);
    wait_done();
    repeat (60) @(posedge sclk); #2;
    chk_rx("ignore_byte", 0, 8'h3C);
    chk("ignore_frames", rx_q.size(), 1);
    chk("ignore_busy_after", tx_busy, 0);
    chk("ignore_done_pulses", done_cnt - d0, 1);

    // Back-to-back: next request in the tx_done cycle
    rx_q.delete(); d0 = done_cnt;
    pulse(8'h01);
    wait_done();
    pi_flag = 1'b1; pi_data = 8'h80;
    @(posedge sclk); #2;
    pi_flag = 1'b0;
    chk("b2b_start_line", rs232_tx, 0);
    chk("b2b_start_busy", tx_busy, 1);
    wait_done();
    chk_rx("b2b_first", 0, 8'h01);
    chk_rx("b2b_second", 1, 8'h80);
    chk("b2b_done_pulses", done_cnt - d0, 2);

    // Reset aborts a frame at cycle 150
    rx_q.delete(); d0 = done_cnt;
    pulse(8'hC3);
    repeat (148) @(posedge sclk);
    @(posedge sclk); #2 s_rst = 1'b1;
    @(posedge sclk); #2 s_rst = 1'b0;
    chk("abort_line", rs232_tx, 1);
    chk("abort_busy", tx_busy, 0);
    repeat (12 * N) @(posedge sclk); #2;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_byte", rx_q.size(), 0);
    pulse(8'h55);
    wait_done();
    chk_rx("abort_recover", 0, 8'h55);
    chk("abort_recover_len", last_busy_len, BUSY_LIT);

`ifdef UART_TX_PARITY_EN
    rx_q.delete();
    pulse(8'h07);
    wait_done();
    chk("parity_bit", rx_par, 1);
    chk("parity_busy_len", last_busy_len, 319);
    chk_rx("parity_byte", 0, 8'h07);
`endif

    // Random traffic, including requests while busy
    repeat (N) @(posedge sclk);
    rx_q.delete(); acc_q.delete();
    repeat (25) begin
      pulse(8'($urandom));
      repeat ($urandom_range(0, 400)) @(posedge sclk);
    end
    for (int i = 0; i < 12 * N; i++) begin
      @(posedge sclk); #2;
      if (tx_busy === 1'b0) break;
    end
    repeat (N) @(posedge sclk); #2;
    chk("rand_busy_end", tx_busy, 0);
    chk("rand_frame_count", rx_q.size(), acc_q.size());
    for (int i = 0; i < acc_q.size(); i++) chk_rx("rand_byte", i, acc_q[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
